// File: rtl/truth_table_checker_pkg.sv
// Shared types for the truth-table checker: FSM state encoding and counter sizing.
// Imported by the top and by the settle counter.
package truth_table_checker_pkg;

  typedef enum logic [1:0] {
    TTC_IDLE   = 2'd0,
    TTC_SETTLE = 2'd1,
    TTC_SAMPLE = 2'd2,
    TTC_DONE   = 2'd3
  } ttc_state_t;

  // Counter must be able to hold SETTLE_CYC itself, never narrower than one bit.
  function automatic int ttc_cnt_width(input int settle_cyc);
    int w;
    w = $clog2(settle_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/truth_table_checker_settle_counter.sv
// Settle-time counter for the truth-table checker: counts hold cycles of one vector
// and flags the last one (cnt == SETTLE_CYC-1).
module truth_table_checker_settle_counter
  import truth_table_checker_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = ttc_cnt_width(SETTLE_CYC);
  localparam logic [CW-1:0] TC_VAL  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYC);

  logic [CW-1:0] cnt;

  // Counting stops at SETTLE_CYC so a stalled enable can never wrap back onto TC_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector of a 1..4-input gate and counts responses that differ from EXPECTED.
// Optional first-failure capture ports are built when TTC_FIRST_FAIL_EN is defined.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int                  N          = 1,
  parameter int                  SETTLE_CYC = 2,
  parameter logic [(1<<N)-1:0]   EXPECTED   = 2'b01
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [N-1:0] dut_in,
  input  logic         dut_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
`ifdef TTC_FIRST_FAIL_EN
  output logic         fail_valid,
  output logic [N-1:0] fail_vec,
  output logic         fail_got,
`endif
  output logic [N:0]   err_count
);

  localparam logic [N-1:0] LAST_VEC = N'((1 << N) - 1);
  localparam logic [N:0]   MAX_ERR  = (N+1)'(1 << N);

  ttc_state_t    state_q, state_d;
  logic [N-1:0]  vec_q;
  logic [N:0]    err_next;
  logic          start_sweep;
  logic          sampling;
  logic          mismatch;
  logic          last_vec;
  logic          settle_tc;

  assign start_sweep = (state_q == TTC_IDLE) && start;
  assign sampling    = (state_q == TTC_SAMPLE);
  assign mismatch    = sampling && (dut_out != EXPECTED[vec_q]);
  assign last_vec    = (vec_q == LAST_VEC);
  assign err_next    = (mismatch && (err_count != MAX_ERR)) ? err_count + (N+1)'(1) : err_count;
  assign dut_in      = vec_q;

  truth_table_checker_settle_counter #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_sweep || sampling),
    .enable (state_q == TTC_SETTLE),
    .tc     (settle_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TTC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TTC_IDLE:   if (start)     state_d = TTC_SETTLE;
      TTC_SETTLE: if (settle_tc) state_d = TTC_SAMPLE;
      TTC_SAMPLE: state_d = last_vec ? TTC_DONE : TTC_SETTLE;
      TTC_DONE:   state_d = TTC_IDLE;
      default:    state_d = TTC_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      TTC_SETTLE, TTC_SAMPLE: busy = 1'b1;
      TTC_DONE:               done = 1'b1;
      default: ;
    endcase
  end

  // pass is loaded from the final error count on the last sample so it is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q     <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else if (start_sweep) begin
      vec_q     <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else if (sampling) begin
      err_count <= err_next;
      if (last_vec) begin
        pass <= (err_next == '0);
      end else begin
        vec_q <= vec_q + N'(1);
      end
    end
  end

`ifdef TTC_FIRST_FAIL_EN
  // Only the first mismatch of a sweep is kept; fail_valid blocks later overwrites.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      fail_got   <= 1'b0;
    end else if (start_sweep) begin
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      fail_got   <= 1'b0;
    end else if (mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_vec   <= vec_q;
      fail_got   <= dut_out;
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomized self-checking bench for truth_table_checker (N=2, AND truth table expected).
// The gate-under-test is a table lookup whose contents are chosen per sweep.
module tb_truth_table_checker;

  localparam int          N           = 2;
  localparam int          SETTLE_CYC  = 2;
  localparam logic [3:0]  EXPECTED    = 4'b1000;
  localparam int          PER         = SETTLE_CYC + 1;
  localparam int          NVEC        = 1 << N;
  localparam int          SWEEP_EDGES = NVEC * PER + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dut_in;
  logic         dut_out;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_count;
  logic [3:0]   gut_tt = 4'b1000;
`ifdef TTC_FIRST_FAIL_EN
  logic         fail_valid;
  logic [N-1:0] fail_vec;
  logic         fail_got;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dut_out = gut_tt[dut_in];

  truth_table_checker #(
    .N          (N),
    .SETTLE_CYC (SETTLE_CYC),
    .EXPECTED   (EXPECTED)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dut_in     (dut_in),
    .dut_out    (dut_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
`ifdef TTC_FIRST_FAIL_EN
    .fail_valid (fail_valid),
    .fail_vec   (fail_vec),
    .fail_got   (fail_got),
`endif
    .err_count  (err_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Number of mismatching vectors among the first nvec vectors of a GUT table.
  function automatic int errsUpTo(input logic [3:0] tt, input int nvec);
    int c;
    c = 0;
    for (int v = 0; v < nvec && v < NVEC; v++)
      if (tt[v] != EXPECTED[v]) c++;
    return c;
  endfunction

  function automatic int firstFail(input logic [3:0] tt);
    for (int v = 0; v < NVEC; v++)
      if (tt[v] != EXPECTED[v]) return v;
    return 0;
  endfunction

  // mode 0: single start pulse, 1: start held through the sweep, 2: extra pulse mid-sweep
  task automatic applyStimulus(input logic [3:0] tt, input int mode);
    int errs;
    int done_seen;
    int completed;
    errs = errsUpTo(tt, NVEC);
    done_seen = 0;
    @(negedge clk);
    gut_tt = tt;
    for (int k = 1; k <= SWEEP_EDGES; k++) begin
      start = (k == 1) || (mode == 1) || (mode == 2 && k == 6);
      @(posedge clk);
      #1;
      completed = (k - 1) / PER;
      if (done) done_seen++;
      if (k < SWEEP_EDGES) begin
        checkOutput("busy_sweep", 32'(busy), 1);
        checkOutput("done_early", 32'(done), 0);
        checkOutput("dut_in_seq", 32'(dut_in), completed);
        checkOutput("pass_cleared", 32'(pass), 0);
      end else begin
        checkOutput("done_pulse", 32'(done), 1);
        checkOutput("busy_done", 32'(busy), 0);
        checkOutput("dut_in_last", 32'(dut_in), NVEC - 1);
        checkOutput("pass_final", 32'(pass), (errs == 0) ? 1 : 0);
      end
      checkOutput("err_count", 32'(err_count), errsUpTo(tt, completed));
`ifdef TTC_FIRST_FAIL_EN
      checkOutput("fail_valid", 32'(fail_valid), (errsUpTo(tt, completed) != 0) ? 1 : 0);
      if (errsUpTo(tt, completed) != 0) begin
        checkOutput("fail_vec", 32'(fail_vec), firstFail(tt));
        checkOutput("fail_got", 32'(fail_got), 32'(tt[firstFail(tt)]));
      end
`endif
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
      checkOutput("idle_busy", 32'(busy), 0);
      checkOutput("idle_dut_in", 32'(dut_in), NVEC - 1);
      checkOutput("idle_err", 32'(err_count), errs);
      checkOutput("idle_pass", 32'(pass), (errs == 0) ? 1 : 0);
    end
    checkOutput("done_count", 32'(done_seen), 1);
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_pass", 32'(pass), 0);
    checkOutput("rst_err", 32'(err_count), 0);
    checkOutput("rst_dut_in", 32'(dut_in), 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(4'b1000, 0);
    applyStimulus(4'b0000, 0);
    applyStimulus(4'b0111, 1);
    applyStimulus(4'b0001, 2);
    applyStimulus(4'b1000, 1);

    // Abort a sweep during the settle of vector 1; reset acts without a clock edge.
    @(negedge clk);
    gut_tt = 4'b0111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_dut_in", 32'(dut_in), 0);
    checkOutput("abort_err", 32'(err_count), 0);
    checkOutput("abort_pass", 32'(pass), 0);
    checkOutput("abort_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    checkOutput("abort_quiet", 32'(done_seen), 0);
    applyStimulus(4'b1000, 0);

    for (int i = 0; i < 10; i++)
      applyStimulus(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
